// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - RV32M op encodings, FSM state constants and op-class helpers
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_e;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_CALC = 2'd1;
   localparam state_t ST_FIX  = 2'd2;
   localparam state_t ST_DONE = 2'd3;

   function automatic logic is_div(op_e op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic is_rem(op_e op);
      return op inside {OP_REM, OP_REMU};
   endfunction

   function automatic logic is_signed_a(op_e op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic is_signed_b(op_e op);
      return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
   endfunction

   function automatic logic returns_high(op_e op);
      return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational iteration: BITS_PER_CYCLE MSB-first
// shift-add (multiply) or restoring shift-subtract (divide) steps on magnitudes
module muldiv_step #(
   parameter int DATA_WIDTH     = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                      i_is_div,
   input  logic [2*DATA_WIDTH-1:0]   i_prod,
   input  logic [DATA_WIDTH:0]       i_rem,
   input  logic [DATA_WIDTH-1:0]     i_shreg,
   input  logic [DATA_WIDTH-1:0]     i_operand,
   output logic [2*DATA_WIDTH-1:0]   o_prod,
   output logic [DATA_WIDTH:0]       o_rem,
   output logic [DATA_WIDTH-1:0]     o_shreg
);
   localparam int W = DATA_WIDTH;

   logic [2*W-1:0] w_p;
   logic [W:0]     w_r;
   logic [W-1:0]   w_s;

   // i_shreg holds the multiplier (consumed MSB first) or the dividend that
   // is progressively replaced by quotient bits from the LSB end.
   always_comb begin
      w_p = i_prod;
      w_r = i_rem;
      w_s = i_shreg;
      for (int k = 0; k < BITS_PER_CYCLE; k++) begin
         if (i_is_div) begin
            w_r = {w_r[W-1:0], w_s[W-1]};
            w_s = {w_s[W-2:0], 1'b0};
            if (w_r >= {1'b0, i_operand}) begin
               w_r    = w_r - {1'b0, i_operand};
               w_s[0] = 1'b1;
            end
         end else begin
            w_p = {w_p[2*W-2:0], 1'b0} + (w_s[W-1] ? {{W{1'b0}}, i_operand} : {(2*W){1'b0}});
            w_s = {w_s[W-2:0], 1'b0};
         end
      end
   end

   assign o_prod  = w_p;
   assign o_rem   = w_r;
   assign o_shreg = w_s;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with
// start/busy/done handshake, kill abort and single-cycle special cases
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  kill,
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] op_a,
   input  logic [DATA_WIDTH-1:0] op_b,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);
   localparam int W     = DATA_WIDTH;
   localparam int N     = DATA_WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = $clog2(N) + 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);
   localparam logic [W-1:0]     MOST_NEG  = {1'b1, {(W-1){1'b0}}};

   state_t           r_state;
   op_e              r_op;
   logic             r_sign_a;
   logic             r_neg;
   logic [2*W-1:0]   r_prod;
   logic [W:0]       r_rem;
   logic [W-1:0]     r_shreg;
   logic [W-1:0]     r_operand;
   logic [CNT_W-1:0] r_cnt;
   logic [W-1:0]     r_result;

   op_e            w_op;
   logic           w_sign_a, w_sign_b, w_div_zero, w_ovf;
   logic [W-1:0]   w_mag_a, w_mag_b, w_special_res;
   logic [2*W-1:0] w_step_prod, w_prod_fix;
   logic [W:0]     w_step_rem;
   logic [W-1:0]   w_step_shreg, w_quo_fix, w_rem_fix, w_fix_res;

   assign w_op       = op_e'(funct3);
   assign w_sign_a   = is_signed_a(w_op) & op_a[W-1];
   assign w_sign_b   = is_signed_b(w_op) & op_b[W-1];
   assign w_mag_a    = w_sign_a ? -op_a : op_a;
   assign w_mag_b    = w_sign_b ? -op_b : op_b;
   assign w_div_zero = is_div(w_op) && (op_b == '0);
   assign w_ovf      = (w_op inside {OP_DIV, OP_REM}) && (op_a == MOST_NEG) && (op_b == '1);
   assign w_special_res = is_rem(w_op) ? (w_div_zero ? op_a : '0)
                                       : (w_div_zero ? '1 : MOST_NEG);

   muldiv_step #(
      .DATA_WIDTH    (DATA_WIDTH),
      .BITS_PER_CYCLE(BITS_PER_CYCLE)
   ) u_step (
      .i_is_div (is_div(r_op)),
      .i_prod   (r_prod),
      .i_rem    (r_rem),
      .i_shreg  (r_shreg),
      .i_operand(r_operand),
      .o_prod   (w_step_prod),
      .o_rem    (w_step_rem),
      .o_shreg  (w_step_shreg)
   );

   // Remainder takes the dividend's sign; product and quotient use a^b.
   assign w_prod_fix = r_neg ? -r_prod : r_prod;
   assign w_quo_fix  = r_neg ? -r_shreg : r_shreg;
   assign w_rem_fix  = r_sign_a ? -r_rem[W-1:0] : r_rem[W-1:0];
   assign w_fix_res  = is_div(r_op) ? (is_rem(r_op) ? w_rem_fix : w_quo_fix)
                                    : (returns_high(r_op) ? w_prod_fix[2*W-1:W] : w_prod_fix[W-1:0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_op      <= OP_MUL;
         r_sign_a  <= 1'b0;
         r_neg     <= 1'b0;
         r_prod    <= '0;
         r_rem     <= '0;
         r_shreg   <= '0;
         r_operand <= '0;
         r_cnt     <= '0;
         r_result  <= '0;
      end else if (kill) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (start) begin
               r_op      <= w_op;
               r_sign_a  <= w_sign_a;
               r_neg     <= w_sign_a ^ w_sign_b;
               r_shreg   <= w_mag_a;
               r_operand <= w_mag_b;
               r_prod    <= '0;
               r_rem     <= '0;
               r_cnt     <= '0;
               if (w_div_zero || w_ovf) begin
                  r_result <= w_special_res;
                  r_state  <= ST_DONE;
               end else begin
                  r_state  <= ST_CALC;
               end
            end
            ST_CALC: begin
               r_prod  <= w_step_prod;
               r_rem   <= w_step_rem;
               r_shreg <= w_step_shreg;
               r_cnt   <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST_STEP) r_state <= ST_FIX;
            end
            ST_FIX: begin
               r_result <= w_fix_res;
               r_state  <= ST_DONE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy   = (r_state != ST_IDLE);
   assign done   = (r_state == ST_DONE);
   assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench: directed table, abort sequences,
// random ops against a 64-bit arithmetic reference, for BITS_PER_CYCLE 1 and 4
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        t_start [2];
   logic        t_kill  [2];
   logic [2:0]  t_f3    [2];
   logic [31:0] t_a     [2];
   logic [31:0] t_b     [2];
   logic        t_busy  [2];
   logic        t_done  [2];
   logic [31:0] t_res   [2];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.DATA_WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(t_start[0]), .kill(t_kill[0]), .funct3(t_f3[0]),
      .op_a(t_a[0]), .op_b(t_b[0]), .busy(t_busy[0]), .done(t_done[0]), .result(t_res[0])
   );

   muldiv_unit #(.DATA_WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(t_start[1]), .kill(t_kill[1]), .funct3(t_f3[1]),
      .op_a(t_a[1]), .op_b(t_b[1]), .busy(t_busy[1]), .done(t_done[1]), .result(t_res[1])
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] p;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      case (op)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
         3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   // Launch in the current cycle (cycle 0); cycles counted from the launch edge.
   // With junk set, start and garbage operands are driven while the op runs.
   task automatic do_op(input int u, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input bit junk,
                        output logic [31:0] res, output int done_cyc, output int ndone, output int busy_bad);
      t_f3[u] = op; t_a[u] = a; t_b[u] = b; t_start[u] = 1'b1;
      @(posedge clk); #1;
      t_start[u] = 1'b0;
      done_cyc = -1; ndone = 0; busy_bad = 0; res = 'x;
      for (int c = 1; c <= 300; c++) begin
         if (t_done[u]) begin
            ndone++;
            if (done_cyc < 0) begin done_cyc = c; res = t_res[u]; end
         end
         if (done_cyc < 0 || c == done_cyc) begin
            if (!t_busy[u]) busy_bad++;
         end else if (t_busy[u]) busy_bad++;
         if (done_cyc >= 0 && c >= done_cyc + 2) break;
         if (junk && c >= 2 && c <= exp_lat) begin
            t_start[u] = 1'b1; t_a[u] = $urandom; t_b[u] = $urandom; t_f3[u] = 3'($urandom);
         end else begin
            t_start[u] = 1'b0;
         end
         @(posedge clk); #1;
      end
      t_start[u] = 1'b0;
   endtask

   task automatic run_checked(input string tag, input int u, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp, input int lat, input bit junk);
      logic [31:0] res;
      int          dc, nd, bb;
      do_op(u, op, a, b, lat, junk, res, dc, nd, bb);
      check({tag, "_result"}, res, exp);
      check({tag, "_done_cycle"}, dc, lat);
      check({tag, "_done_count"}, nd, 1);
      check({tag, "_busy_errs"}, bb, 0);
   endtask

   initial begin
      vec_t        vecs[$];
      logic [31:0] prev, res;
      logic [2:0]  op;
      logic [31:0] a, b;
      int          dc, nd, bb, seen_done;

      for (int u = 0; u < 2; u++) begin
         t_start[u] = 0; t_kill[u] = 0; t_f3[u] = 0; t_a[u] = 0; t_b[u] = 0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
         check($sformatf("reset_busy%0d", u), t_busy[u], 0);
         check($sformatf("reset_done%0d", u), t_done[u], 0);
         check($sformatf("reset_result%0d", u), t_res[u], 0);
      end
      rst = 1'b0;

      vecs.push_back('{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
      vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34});
      vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
      vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34});
      vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34});
      vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34});
      vecs.push_back('{3'b101, 32'd100,       32'd7,         32'd14,        34});
      vecs.push_back('{3'b111, 32'd100,       32'd7,         32'd2,         34});
      vecs.push_back('{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1});
      vecs.push_back('{3'b111, 32'd5,         32'd0,         32'd5,         1});
      vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
      vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1});
      vecs.push_back('{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34});
      vecs.push_back('{3'b110, 32'hFFFF_FFF3, 32'd0,         32'hFFFF_FFF3, 1});
      vecs.push_back('{3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34});
      foreach (vecs[i])
         run_checked($sformatf("vec%0d", i), 0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, i % 2 == 1);

      // kill in cycle 10 of a DIVU, relaunch in cycle 11
      prev = t_res[0];
      t_f3[0] = 3'b101; t_a[0] = 32'd100; t_b[0] = 32'd7; t_start[0] = 1'b1;
      @(posedge clk); #1;
      t_start[0] = 1'b0;
      seen_done = 0;
      for (int c = 1; c < 10; c++) begin
         seen_done += int'(t_done[0]);
         @(posedge clk); #1;
      end
      check("kill_busy_c10", t_busy[0], 1);
      t_kill[0] = 1'b1;
      @(posedge clk); #1;
      t_kill[0] = 1'b0;
      check("kill_busy_c11", t_busy[0], 0);
      check("kill_done_c11", t_done[0], 0);
      check("kill_result_kept", t_res[0], prev);
      check("kill_no_done_pulse", seen_done, 0);
      do_op(0, 3'b111, 32'd100, 32'd7, 34, 1'b0, res, dc, nd, bb);
      check("relaunch_done_cycle", dc + 11, 45);
      check("relaunch_result", res, 32'd2);
      check("relaunch_done_count", nd, 1);

      // kill beats start in the same cycle
      t_f3[0] = 3'b000; t_a[0] = 32'd3; t_b[0] = 32'd5; t_start[0] = 1'b1; t_kill[0] = 1'b1;
      @(posedge clk); #1;
      t_start[0] = 1'b0; t_kill[0] = 1'b0;
      check("kill_prio_busy", t_busy[0], 0);
      check("kill_prio_result", t_res[0], 32'd2);

      // rst mid-CALC
      t_f3[0] = 3'b000; t_a[0] = 32'd3; t_b[0] = 32'd5; t_start[0] = 1'b1;
      @(posedge clk); #1;
      t_start[0] = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("rst_mid_busy_before", t_busy[0], 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_mid_busy", t_busy[0], 0);
      check("rst_mid_result", t_res[0], 0);
      @(posedge clk); #1;
      check("rst_mid_done", t_done[0], 0);

      // BITS_PER_CYCLE=4 directed, with start hammered while busy
      run_checked("bpc4_mul", 1, 3'b000, 32'd12345, 32'd678, 32'd8369910, 10, 1'b1);
      run_checked("bpc4_divsp", 1, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
      run_checked("bpc4_rem", 1, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 10, 1'b0);

      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7)); a = pick(); b = pick();
         run_checked($sformatf("rnd1_%0d_op%0d", i, op), 0, op, a, b, ref_model(op, a, b),
                     is_special(op, a, b) ? 1 : 34, 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 30; i++) begin
         op = 3'($urandom_range(0, 7)); a = pick(); b = pick();
         run_checked($sformatf("rnd4_%0d_op%0d", i, op), 1, op, a, b, ref_model(op, a, b),
                     is_special(op, a, b) ? 1 : 10, 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
